// File: rtl/mpt_plb.sv
// Permission lookaside buffer for the MPT path: fully associative per-4KiB-page permission cache with a single outstanding walk.
// Optional hit/miss performance counters are built when MPT_PLB_PERF_CNT_EN is defined.
module mpt_plb #(
  parameter int PLB_ENTRIES = 8,
  parameter int PLEN        = 34,
  parameter int SDID_LEN    = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [PLEN-1:0]          req_spa_i,
  input  logic [SDID_LEN-1:0]      req_sdid_i,
  input  logic [1:0]               req_access_i,
  output logic                     rsp_valid_o,
  output logic                     rsp_allow_o,
  output logic                     rsp_fault_o,
  output logic                     ptw_req_valid_o,
  input  logic                     ptw_req_ready_i,
  output logic [PLEN-1:0]          ptw_spa_o,
  output logic [SDID_LEN-1:0]      ptw_sdid_o,
  input  logic                     ptw_rsp_valid_i,
  input  logic [SDID_LEN+PLEN+1:0] ptw_rsp_entry_i,
  input  logic                     ptw_rsp_error_i,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
);
  localparam int IDX_W   = $clog2(PLB_ENTRIES);
  localparam int TAG_W   = SDID_LEN + PLEN - 12;
  localparam int ENTRY_W = SDID_LEN + PLEN + 2;

  localparam logic [1:0] ACC_READ  = 2'd1;
  localparam logic [1:0] ACC_WRITE = 2'd2;
  localparam logic [1:0] ACC_EXEC  = 2'd3;

  localparam logic [1:0] PERM_DISALLOWED = 2'd0;
  localparam logic [1:0] PERM_ALLOW_RX   = 2'd1;
  localparam logic [1:0] PERM_ALLOW_RW   = 2'd2;
  localparam logic [1:0] PERM_ALLOW_RWX  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RESPOND, S_MISS_REQ, S_MISS_WAIT} state_e;

  function automatic logic perm_allows(input logic [1:0] perm, input logic [1:0] acc);
    case (acc)
      ACC_READ:  return perm != PERM_DISALLOWED;
      ACC_WRITE: return (perm == PERM_ALLOW_RW) || (perm == PERM_ALLOW_RWX);
      ACC_EXEC:  return (perm == PERM_ALLOW_RX) || (perm == PERM_ALLOW_RWX);
      default:   return 1'b1;
    endcase
  endfunction

  state_e                   state_q, state_d;
  logic [PLB_ENTRIES-1:0]   valid_q, valid_d;
  logic [IDX_W-1:0]         rr_q, rr_d;
  logic                     drop_q, drop_d;
  logic [PLEN-1:0]          spa_q, spa_d;
  logic [SDID_LEN-1:0]      sdid_q, sdid_d;
  logic [1:0]               acc_q, acc_d;
  logic                     allow_q, allow_d;
  logic                     fault_q, fault_d;
  logic [TAG_W-1:0]         tag_q  [PLB_ENTRIES];
  logic [1:0]               perm_q [PLB_ENTRIES];

  logic [TAG_W-1:0]         req_tag;
  logic                     hit;
  logic [1:0]               hit_perm;
  logic [IDX_W-1:0]         victim_idx;
  logic                     victim_free;
  logic                     fill_we;
  logic [IDX_W-1:0]         fill_idx;

  // Entry layout is {sdid, spa, perm}; only the permissions are consumed.
  logic unused_entry_bits;
  assign unused_entry_bits = ^ptw_rsp_entry_i[ENTRY_W-1:2];

  assign req_tag = {req_sdid_i, req_spa_i[PLEN-1:12]};

  always_comb begin
    hit      = 1'b0;
    hit_perm = '0;
    for (int i = 0; i < PLB_ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit      = 1'b1;
        hit_perm = hit_perm | perm_q[i];
      end
    end
    // A flush on the accept edge wipes the entry being looked up.
    if (flush_i) hit = 1'b0;
  end

  always_comb begin
    victim_idx  = rr_q;
    victim_free = 1'b0;
    for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim_idx  = IDX_W'(i);
        victim_free = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    rr_d     = rr_q;
    drop_d   = drop_q;
    spa_d    = spa_q;
    sdid_d   = sdid_q;
    acc_d    = acc_q;
    allow_d  = allow_q;
    fault_d  = fault_q;
    fill_we  = 1'b0;
    fill_idx = victim_idx;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (req_valid_i) begin
          spa_d  = req_spa_i;
          sdid_d = req_sdid_i;
          acc_d  = req_access_i;
          if (hit) begin
            allow_d = perm_allows(hit_perm, req_access_i);
            fault_d = 1'b0;
            state_d = S_RESPOND;
          end else begin
            state_d = S_MISS_REQ;
          end
        end
      end
      S_MISS_REQ: if (ptw_req_ready_i) state_d = S_MISS_WAIT;
      S_MISS_WAIT: begin
        if (ptw_rsp_valid_i) begin
          state_d = S_RESPOND;
          if (ptw_rsp_error_i) begin
            allow_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            allow_d = perm_allows(ptw_rsp_entry_i[1:0], acc_q);
            fault_d = 1'b0;
            fill_we = !drop_q && !flush_i;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fill_we) begin
      valid_d[fill_idx] = 1'b1;
      if (!victim_free) rr_d = rr_q + 1'b1;
    end
    if (flush_i) begin
      valid_d = '0;
      if ((state_q == S_MISS_REQ) || (state_q == S_MISS_WAIT)) drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      rr_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    spa_q   <= spa_d;
    sdid_q  <= sdid_d;
    acc_q   <= acc_d;
    allow_q <= allow_d;
    fault_q <= fault_d;
    if (fill_we) begin
      tag_q[fill_idx]  <= {sdid_q, spa_q[PLEN-1:12]};
      perm_q[fill_idx] <= ptw_rsp_entry_i[1:0];
    end
  end

  assign req_ready_o     = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o     = (state_q == S_RESPOND) && !rst_i;
  assign rsp_allow_o     = rsp_valid_o && allow_q;
  assign rsp_fault_o     = rsp_valid_o && fault_q;
  assign ptw_req_valid_o = (state_q == S_MISS_REQ) && !rst_i;
  assign ptw_spa_o       = rst_i ? '0 : spa_q;
  assign ptw_sdid_o      = rst_i ? '0 : sdid_q;

`ifdef MPT_PLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && req_valid_i;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (flush_i) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (accept) begin
      if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mpt_plb.sv
// Directed bench for mpt_plb: hit/miss paths, replacement, walk errors, SDID tagging, flush, stalls, reset and counters.
module tb_mpt_plb;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [33:0] req_spa_i = '0;
  logic [5:0]  req_sdid_i = '0;
  logic [1:0]  req_access_i = '0;
  logic        rsp_valid_o, rsp_allow_o, rsp_fault_o;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready_i = 1'b0;
  logic [33:0] ptw_spa_o;
  logic [5:0]  ptw_sdid_o;
  logic        ptw_rsp_valid_i = 1'b0;
  logic [41:0] ptw_rsp_entry_i = '0;
  logic        ptw_rsp_error_i = 1'b0;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] READ = 2'd1, WRITE = 2'd2, EXEC = 2'd3;
  localparam logic [1:0] DIS = 2'd0, RX = 2'd1, RW = 2'd2, RWX = 2'd3;

  mpt_plb dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_spa_i(req_spa_i), .req_sdid_i(req_sdid_i), .req_access_i(req_access_i),
    .rsp_valid_o(rsp_valid_o), .rsp_allow_o(rsp_allow_o), .rsp_fault_o(rsp_fault_o),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready_i),
    .ptw_spa_o(ptw_spa_o), .ptw_sdid_o(ptw_sdid_o),
    .ptw_rsp_valid_i(ptw_rsp_valid_i), .ptw_rsp_entry_i(ptw_rsp_entry_i),
    .ptw_rsp_error_i(ptw_rsp_error_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  // Issues one request and services a walk if one appears; returns what was observed.
  task automatic run_access(input logic [33:0] spa, input logic [5:0] sdid, input logic [1:0] acc,
                            input logic [1:0] perm, input logic err, input int stall, input logic flush_wait,
                            output logic ready, output logic hit, output logic walked,
                            output logic [33:0] wspa, output logic [5:0] wsdid,
                            output logic rsp, output logic allow, output logic fault, output logic stable);
    hit = 0; walked = 0; wspa = '0; wsdid = '0; rsp = 0; allow = 0; fault = 0; stable = 1;
    @(negedge clk);
    req_valid_i = 1; req_spa_i = spa; req_sdid_i = sdid; req_access_i = acc;
    ready = req_ready_o;
    @(posedge clk); #1;
    req_valid_i = 0;
    if (rsp_valid_o) begin
      hit = 1; rsp = 1; allow = rsp_allow_o; fault = rsp_fault_o;
    end else if (ptw_req_valid_o) begin
      walked = 1; wspa = ptw_spa_o; wsdid = ptw_sdid_o;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        if (!ptw_req_valid_o || ptw_spa_o != wspa || ptw_sdid_o != wsdid || req_ready_o) stable = 0;
      end
      ptw_req_ready_i = 1;
      @(posedge clk); #1;
      ptw_req_ready_i = 0;
      if (flush_wait) begin
        flush_i = 1;
        @(posedge clk); #1;
        flush_i = 0;
      end
      ptw_rsp_valid_i = 1; ptw_rsp_error_i = err;
      ptw_rsp_entry_i = {6'h2A, 34'h3_FFFF_F000, perm};
      @(posedge clk); #1;
      ptw_rsp_valid_i = 0; ptw_rsp_error_i = 0;
      rsp = rsp_valid_o; allow = rsp_allow_o; fault = rsp_fault_o;
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse_flush();
    @(negedge clk); flush_i = 1;
    @(negedge clk); flush_i = 0;
  endtask

  logic r_ready, r_hit, r_walked, r_rsp, r_allow, r_fault, r_stable;
  logic [33:0] r_wspa;
  logic [5:0]  r_wsdid;

  task automatic test_reset();
    rst_i = 1; req_valid_i = 1; req_spa_i = 34'h1_2345_6000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_allow_o, rsp_fault_o, ptw_req_valid_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {req_ready_o, rsp_valid_o, rsp_allow_o, rsp_fault_o, ptw_req_valid_o});
    end
    checks++;
    if (ptw_spa_o !== 34'h0 || ptw_sdid_o !== 6'h0) begin
      errors++; $display("FAIL reset_ptw_addr got %h/%h want 0/0", ptw_spa_o, ptw_sdid_o);
    end
    checks++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o);
    end
    req_valid_i = 0;
    @(negedge clk); rst_i = 0;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
  endtask

  task automatic test_basic();
    run_access(34'h0_1234_5000, 6'd3, READ, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_ready !== 1 || r_hit !== 0 || r_walked !== 1) begin
      errors++; $display("FAIL basic_miss ready/hit/walk got %b%b%b want 101", r_ready, r_hit, r_walked);
    end
    checks++;
    if (r_wspa !== 34'h0_1234_5000 || r_wsdid !== 6'd3) begin
      errors++; $display("FAIL basic_walk_addr got %h/%0d want 012345000/3", r_wspa, r_wsdid);
    end
    checks++;
    if ({r_rsp, r_allow, r_fault} !== 3'b110) begin
      errors++; $display("FAIL basic_miss_rsp got %b want 110", {r_rsp, r_allow, r_fault});
    end
    run_access(34'h0_1234_5000, 6'd3, WRITE, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_hit, r_walked, r_allow, r_fault} !== 4'b1000) begin
      errors++; $display("FAIL basic_write_hit hit/walk/allow/fault got %b want 1000", {r_hit, r_walked, r_allow, r_fault});
    end
    run_access(34'h0_1234_5FFF, 6'd3, EXEC, DIS, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_hit, r_allow} !== 2'b11) begin
      errors++; $display("FAIL basic_exec_hit hit/allow got %b want 11", {r_hit, r_allow});
    end
    checks++;
    if (rsp_valid_o !== 0 || rsp_allow_o !== 0) begin
      errors++; $display("FAIL basic_rsp_pulse valid/allow got %b%b want 00", rsp_valid_o, rsp_allow_o);
    end
  endtask

  task automatic test_replacement();
    int misses;
    pulse_flush();
    misses = 0;
    for (int i = 0; i < 9; i++) begin
      run_access(34'h1_0000_0000 + 34'(i << 12), 6'd1, READ, RX, 0, 0, 0,
                 r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
      if (r_walked && r_allow) misses++;
    end
    checks++;
    if (misses !== 9) begin errors++; $display("FAIL repl_fill9 misses got %0d want 9", misses); end
    run_access(34'h1_0000_1000, 6'd1, READ, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_hit !== 1) begin errors++; $display("FAIL repl_page1_hit got %b want 1", r_hit); end
    run_access(34'h1_0000_0000, 6'd1, READ, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_hit !== 0 || r_walked !== 1) begin errors++; $display("FAIL repl_page0_miss hit/walk got %b%b want 01", r_hit, r_walked); end
  endtask

  task automatic test_error();
    run_access(34'h2_0000_7000, 6'd2, READ, RWX, 1, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_walked, r_rsp, r_allow, r_fault} !== 4'b1101) begin
      errors++; $display("FAIL err_rsp walk/rsp/allow/fault got %b want 1101", {r_walked, r_rsp, r_allow, r_fault});
    end
    run_access(34'h2_0000_7000, 6'd2, WRITE, RWX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_walked, r_allow, r_fault} !== 3'b110) begin
      errors++; $display("FAIL err_retry walk/allow/fault got %b want 110", {r_walked, r_allow, r_fault});
    end
    run_access(34'h2_0000_7000, 6'd2, EXEC, DIS, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_hit, r_allow} !== 2'b11) begin errors++; $display("FAIL err_refill_hit hit/allow got %b want 11", {r_hit, r_allow}); end
  endtask

  task automatic test_sdid();
    run_access(34'h0_0ABC_D000, 6'd3, READ, RW, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    run_access(34'h0_0ABC_D000, 6'd4, READ, DIS, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_walked !== 1 || r_wsdid !== 6'd4) begin
      errors++; $display("FAIL sdid_miss walk/sdid got %b/%0d want 1/4", r_walked, r_wsdid);
    end
    checks++;
    if ({r_allow, r_fault} !== 2'b00) begin errors++; $display("FAIL sdid_disallowed got %b want 00", {r_allow, r_fault}); end
    run_access(34'h0_0ABC_D000, 6'd3, EXEC, RWX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_hit, r_allow} !== 2'b10) begin errors++; $display("FAIL sdid3_exec_hit hit/allow got %b want 10", {r_hit, r_allow}); end
  endtask

  task automatic test_flush();
    run_access(34'h3_0000_2000, 6'd1, READ, RX, 0, 0, 1,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if ({r_walked, r_rsp, r_allow, r_fault} !== 4'b1110) begin
      errors++; $display("FAIL flush_wait_rsp got %b want 1110", {r_walked, r_rsp, r_allow, r_fault});
    end
    run_access(34'h3_0000_2000, 6'd1, READ, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_hit !== 0 || r_walked !== 1) begin errors++; $display("FAIL flush_dropped_fill hit/walk got %b%b want 01", r_hit, r_walked); end
    run_access(34'h3_0000_2000, 6'd1, READ, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_hit !== 1) begin errors++; $display("FAIL flush_refill_hit got %b want 1", r_hit); end
    pulse_flush();
    run_access(34'h3_0000_2000, 6'd1, READ, RX, 0, 0, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_hit !== 0 || r_walked !== 1) begin errors++; $display("FAIL flush_idle_miss hit/walk got %b%b want 01", r_hit, r_walked); end
  endtask

  task automatic test_stall();
    run_access(34'h0_5555_5000, 6'd9, WRITE, RWX, 0, 5, 0,
               r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    checks++;
    if (r_walked !== 1 || r_stable !== 1) begin errors++; $display("FAIL stall_stable walk/stable got %b%b want 11", r_walked, r_stable); end
    checks++;
    if (r_wspa !== 34'h0_5555_5000 || {r_rsp, r_allow} !== 2'b11) begin
      errors++; $display("FAIL stall_rsp spa %h rsp/allow %b want 055555000 11", r_wspa, {r_rsp, r_allow});
    end
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    req_valid_i = 1; req_spa_i = 34'h0_6666_6000; req_sdid_i = 6'd5; req_access_i = READ;
    @(posedge clk); #1;
    req_valid_i = 0;
    checks++;
    if (ptw_req_valid_o !== 1) begin errors++; $display("FAIL midreset_walk got %b want 1", ptw_req_valid_o); end
    rst_i = 1;
    @(posedge clk); #1;
    rst_i = 0;
    checks++;
    if (ptw_req_valid_o !== 0) begin errors++; $display("FAIL midreset_drop got %b want 0", ptw_req_valid_o); end
    ptw_rsp_valid_i = 1; ptw_rsp_entry_i = {6'd5, 34'h0_6666_6000, RWX};
    @(posedge clk); #1;
    ptw_rsp_valid_i = 0;
    checks++;
    if ({rsp_valid_o, req_ready_o, ptw_req_valid_o} !== 3'b010) begin
      errors++; $display("FAIL midreset_late_rsp valid/ready/ptw got %b want 010", {rsp_valid_o, req_ready_o, ptw_req_valid_o});
    end
  endtask

  task automatic test_counters();
    logic [31:0] want_hit, want_miss;
    pulse_flush();
    run_access(34'h0_7000_0000, 6'd1, READ, RX, 0, 0, 0, r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    run_access(34'h0_7000_0000, 6'd1, READ, RX, 0, 0, 0, r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    run_access(34'h0_7000_0000, 6'd1, EXEC, RX, 0, 0, 0, r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    run_access(34'h0_7000_1000, 6'd1, READ, RX, 0, 0, 0, r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
    run_access(34'h0_7000_1000, 6'd1, READ, RX, 0, 0, 0, r_ready, r_hit, r_walked, r_wspa, r_wsdid, r_rsp, r_allow, r_fault, r_stable);
`ifdef MPT_PLB_PERF_CNT_EN
    want_hit = 32'd3; want_miss = 32'd2;
`else
    want_hit = 32'd0; want_miss = 32'd0;
`endif
    checks++;
    if (hit_cnt_o !== want_hit || miss_cnt_o !== want_miss) begin
      errors++; $display("FAIL counters got %0d/%0d want %0d/%0d", hit_cnt_o, miss_cnt_o, want_hit, want_miss);
    end
    pulse_flush();
    checks++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      errors++; $display("FAIL counters_flush got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_replacement();
    test_error();
    test_sdid();
    test_flush();
    test_stall();
    test_reset_mid_miss();
    test_counters();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without summary");
    $fatal(1);
  end
endmodule

// File: doc/mpt_plb.md
# mpt_plb

Permission Lookaside Buffer for the Memory Protection Table (MPT) path. It caches `plb_entry_t` results (SDID, SPA, 2-bit permissions) per 4 KiB page and answers access checks from the core/IOMMU side. On a miss it issues one walk request to the MPT walker downstream, fills the returned entry, and answers the original request. It sits between the access-check requester and the walker, and is the only consumer of walker results.

## Interface
- `PLB_ENTRIES`, 8, number of fully associative entries (power of two, 2..32)
- `PLEN`, 34, supervisor physical address width
- `SDID_LEN`, 6, supervisor domain ID width

Ports:
- `clk_i` in 1: clock
- `rst_i` in 1: reset; synchronous, active-high
- `flush_i` in 1: invalidate all entries
- `req_valid_i` in 1: access-check request
- `req_ready_o` out 1: request accepted when both are high
- `req_spa_i` in PLEN: SPA to check
- `req_sdid_i` in SDID_LEN: domain of the access
- `req_access_i` in 2: `mpt_access_e` (NONE/READ/WRITE/EXEC)
- `rsp_valid_o` out 1: one-cycle response pulse; no backpressure
- `rsp_allow_o` out 1: access permitted
- `rsp_fault_o` out 1: walker reported a format/access error
- `ptw_req_valid_o` out 1: walk request
- `ptw_req_ready_i` in 1: walker accepts
- `ptw_spa_o` out PLEN: SPA to walk; held stable while valid
- `ptw_sdid_o` out SDID_LEN: domain to walk
- `ptw_rsp_valid_i` in 1: walk result valid (single-cycle)
- `ptw_rsp_entry_i` in SDID_LEN+PLEN+2: `plb_entry_t` result
- `ptw_rsp_error_i` in 1: walk ended in ERROR state
- `hit_cnt_o`, `miss_cnt_o` out 32 each: see Configuration

## Operation
- Tag is {SDID, SPA[PLEN-1:12]}. Each entry has a valid bit, tag, and `mpt_permissions_e`.
- Permission decode:
  - READ: allowed unless DISALLOWED
  - WRITE: allowed on RW or RWX
  - EXEC: allowed on RX or RWX
  - NONE: always allowed
- FSM states: IDLE, RESPOND, MISS_REQ, MISS_WAIT.
- IDLE: `req_ready_o`=1. On accept, the request is registered and a lookup is done.
  - Hit: go to RESPOND.
  - Miss: go to MISS_REQ.
  - Multiple hits cannot occur (single outstanding miss, no duplicate fills).
- MISS_REQ: `ptw_req_valid_o`=1 with the registered SPA/SDID. On `ptw_req_ready_i`, go to MISS_WAIT.
- MISS_WAIT: on `ptw_rsp_valid_i`, go to RESPOND.
  - Error: no fill; respond with allow=0, fault=1.
  - No error: write the permissions under the registered tag (the `SPA`/`SDID` fields of `ptw_rsp_entry_i` are ignored); respond from the returned permissions, fault=0.
- RESPOND: `rsp_valid_o`=1 for one cycle, then go to IDLE. `req_ready_o`=0 in every state except IDLE.
- Victim selection: the lowest-index invalid entry; if none, the round-robin pointer. The pointer increments modulo PLB_ENTRIES only when it is used.
- `ptw_rsp_valid_i` outside MISS_WAIT is ignored.
- Flush:
  - `flush_i` clears all valid bits on that edge in any state.
  - Flush during MISS_REQ/MISS_WAIT: the walk continues and a response is still delivered, but the fill is dropped (sticky drop flag, cleared in IDLE).
  - Flush coincident with a fill: the flush wins and no entry is written.
  - Flush coincident with a request accept in IDLE: the lookup misses.

## Timing
- Reset: state IDLE, all valid bits 0, RR pointer 0, counters 0.
- Output values during reset: `req_ready_o`=0, `rsp_*`=0, `ptw_req_valid_o`=0, `ptw_spa_o`/`ptw_sdid_o`=0.
- Hit latency: `rsp_valid_o` rises 1 cycle after the accept edge.
- Miss latency: `ptw_req_valid_o` rises 1 cycle after accept; `rsp_valid_o` rises 1 cycle after the `ptw_rsp_valid_i` edge.
- `rsp_allow_o`/`rsp_fault_o` are valid only with `rsp_valid_o` and are 0 otherwise.
- A filled entry is visible to the next request accepted after RESPOND.
- Reset mid-miss: `ptw_req_valid_o` drops next cycle; a late walker response is ignored.

## Configuration
- `MPT_PLB_PERF_CNT_EN` defined:
  - `hit_cnt_o` increments on each accepted hit; `miss_cnt_o` on each accepted miss.
  - Both saturate at 2^32-1 and clear on reset or flush.
- Not defined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Reset, then READ SPA 0x0_1234_5000, SDID 3 -> miss; `ptw_req_valid_o` carries the same SPA/SDID; walker returns ALLOW_RX -> `rsp_allow_o`=1; repeat as WRITE -> hit, 1-cycle latency, allow=0, no walk.
- Fill 9 distinct pages with PLB_ENTRIES=8 -> the 9th replaces entry 0 (RR); re-access page 1 -> hit, page 0 -> miss.
- Walker returns `ptw_rsp_error_i`=1 -> fault=1, allow=0; a retry to the same page misses again.
- Same page with SDID 3 filled, then accessed with SDID 4 -> miss and walk with `ptw_sdid_o`=4.
- `flush_i` during MISS_WAIT -> the response is still delivered, the entry is not filled, and a later access misses; `flush_i` in IDLE -> all pages miss.
- Hold `ptw_req_ready_i`=0 for 5 cycles -> `ptw_req_valid_o` and the address stay stable and `req_ready_o`=0 throughout; with `MPT_PLB_PERF_CNT_EN`, after 3 hits and 2 misses the counters read 3/2.
